// File: rtl/game_timer_display_if.sv
// Control and display bundle of the MM:SS countdown timer. The divider levels and
// the start/pause requests go in; segment, digit, separator and status drive come out.
interface game_timer_display_if;
    logic       segClock;
    logic       oneHzClock;
    logic       start;
    logic       pause;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;
    logic       running;
    logic       time_up;

    modport master (
        output segClock, oneHzClock, start, pause,
        input  seg, an, dp, running, time_up
    );

    modport slave (
        input  segClock, oneHzClock, start, pause,
        output seg, an, dp, running, time_up
    );
endinterface

// File: rtl/game_timer_display.sv
// MM:SS countdown timer held as four BCD digits, driving a 4-digit multiplexed
// active-low 7-segment display. All outputs are registered, one clk behind state.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_IDLE  | time loaded with START value, waiting for start
//   S_RUN   | counting down one second per 1 Hz tick
//   S_PAUSE | time frozen, colon blinks, pause resumes, start reloads
//   S_DONE  | time is 00:00, all digits blink, start reloads and reruns
module game_timer_display #(
    parameter int START_MIN = 3,
    parameter int START_SEC = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    game_timer_display_if.slave   tmr
);

    localparam logic [3:0] LD_MT   = 4'(START_MIN / 10);
    localparam logic [3:0] LD_MO   = 4'(START_MIN % 10);
    localparam logic [3:0] LD_ST   = 4'(START_SEC / 10);
    localparam logic [3:0] LD_SO   = 4'(START_SEC % 10);
    localparam logic       LD_ZERO = (START_MIN == 0) && (START_SEC == 0);
    localparam logic [6:0] BLANK   = 7'b1111111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_mt, r_mo, r_st, r_so;
    logic [3:0] w_mt_nxt, w_mo_nxt, w_st_nxt, w_so_nxt;
    logic [3:0] w_dec_mt, w_dec_mo, w_dec_st, w_dec_so;
    logic       w_dec_zero;
    logic       r_seg_prev, r_hz_prev;
    logic       w_seg_tick, w_hz_tick;
    logic [1:0] r_idx;
    logic [3:0] w_digit;
    logic [6:0] w_seg;
    logic [3:0] w_an;
    logic       w_dp;

    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = BLANK;
        endcase
        return s;
    endfunction

    assign w_seg_tick = tmr.segClock   & ~r_seg_prev;
    assign w_hz_tick  = tmr.oneHzClock & ~r_hz_prev;

    // One-second BCD decrement with borrow; saturates at 00:00.
    always_comb begin
        w_dec_mt = r_mt;
        w_dec_mo = r_mo;
        w_dec_st = r_st;
        w_dec_so = r_so;
        if (r_so != 4'd0) begin
            w_dec_so = r_so - 4'd1;
        end else if (r_st != 4'd0) begin
            w_dec_so = 4'd9;
            w_dec_st = r_st - 4'd1;
        end else if (r_mo != 4'd0) begin
            w_dec_so = 4'd9;
            w_dec_st = 4'd5;
            w_dec_mo = r_mo - 4'd1;
        end else if (r_mt != 4'd0) begin
            w_dec_so = 4'd9;
            w_dec_st = 4'd5;
            w_dec_mo = 4'd9;
            w_dec_mt = r_mt - 4'd1;
        end
    end

    assign w_dec_zero = (w_dec_mt == 4'd0) && (w_dec_mo == 4'd0) &&
                        (w_dec_st == 4'd0) && (w_dec_so == 4'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_mt_nxt    = r_mt;
        w_mo_nxt    = r_mo;
        w_st_nxt    = r_st;
        w_so_nxt    = r_so;
        case (r_state)
            S_IDLE: begin
                if (tmr.start) begin
                    w_state_nxt = LD_ZERO ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_hz_tick) begin
                    w_mt_nxt = w_dec_mt;
                    w_mo_nxt = w_dec_mo;
                    w_st_nxt = w_dec_st;
                    w_so_nxt = w_dec_so;
                    if (w_dec_zero) begin
                        w_state_nxt = S_DONE;
                    end else if (tmr.pause) begin
                        w_state_nxt = S_PAUSE;
                    end
                end else if (tmr.pause) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (tmr.start) begin
                    w_mt_nxt    = LD_MT;
                    w_mo_nxt    = LD_MO;
                    w_st_nxt    = LD_ST;
                    w_so_nxt    = LD_SO;
                    w_state_nxt = S_IDLE;
                end else if (tmr.pause) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                if (tmr.start) begin
                    w_mt_nxt    = LD_MT;
                    w_mo_nxt    = LD_MO;
                    w_st_nxt    = LD_ST;
                    w_so_nxt    = LD_SO;
                    w_state_nxt = LD_ZERO ? S_DONE : S_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mt       <= LD_MT;
            r_mo       <= LD_MO;
            r_st       <= LD_ST;
            r_so       <= LD_SO;
            r_idx      <= 2'd0;
            r_seg_prev <= 1'b0;
            r_hz_prev  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mt       <= w_mt_nxt;
            r_mo       <= w_mo_nxt;
            r_st       <= w_st_nxt;
            r_so       <= w_so_nxt;
            r_idx      <= r_idx + {1'b0, w_seg_tick};
            r_seg_prev <= tmr.segClock;
            r_hz_prev  <= tmr.oneHzClock;
        end
    end

    // Display path works from registered state so every output lags by one clk.
    always_comb begin
        case (r_idx)
            2'd0:    w_digit = r_so;
            2'd1:    w_digit = r_st;
            2'd2:    w_digit = r_mo;
            default: w_digit = r_mt;
        endcase
        w_seg = f_decode(w_digit);
        if ((r_idx == 2'd3) && (r_mt == 4'd0)) begin
            w_seg = BLANK;
        end
        if ((r_state == S_DONE) && !r_hz_prev) begin
            w_seg = BLANK;
        end
        w_an = ~(4'b0001 << r_idx);
        w_dp = !((r_idx == 2'd2) && ((r_state != S_PAUSE) || r_hz_prev));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmr.seg     <= f_decode(LD_SO);
            tmr.an      <= 4'b1110;
            tmr.dp      <= 1'b1;
            tmr.running <= 1'b0;
            tmr.time_up <= 1'b0;
        end else begin
            tmr.seg     <= w_seg;
            tmr.an      <= w_an;
            tmr.dp      <= w_dp;
            tmr.running <= (r_state == S_RUN);
            tmr.time_up <= (r_state == S_DONE);
        end
    end

endmodule

// File: doc/game_timer_display.md
GAME_TIMER_DISPLAY -- requirements
Module: game_timer_display

Interface
REQ-001 SHALL have parameter START_MIN, default 3, countdown load value for minutes, legal range 0..99.
REQ-002 SHALL have parameter START_SEC, default 0, countdown load value for seconds, legal range 0..59; out-of-range parameter values are unsupported.
REQ-003 SHALL have port clk  in  1  master clock; the only clock, all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port segClock  in  1  500 Hz divided level from the clock divider, sampled on clk.
REQ-006 SHALL have port oneHzClock  in  1  1 Hz divided level from the clock divider, sampled on clk.
REQ-007 SHALL have port start  in  1  single-cycle start/restart request.
REQ-008 SHALL have port pause  in  1  single-cycle pause/resume toggle request.
REQ-009 SHALL have port seg  out  7  active-low segment drive, seg[0]=a ... seg[6]=g.
REQ-010 SHALL have port an  out  4  active-low digit enables, an[0]=seconds ones ... an[3]=minutes tens.
REQ-011 SHALL have port dp  out  1  active-low decimal point, used as the MM:SS separator.
REQ-012 SHALL have port running  out  1  high while in state RUN.
REQ-013 SHALL have port time_up  out  1  high while in state DONE.

Function
REQ-014 SHALL register segClock and oneHzClock each cycle; a tick is current=1 and previous=0, one clk cycle wide.
REQ-015 SHALL hold time as four BCD digits: mt (0-9), mo (0-9), st (0-5), so (0-9).
REQ-016 SHALL implement states IDLE, RUN, PAUSE, DONE.
REQ-017 IDLE: start -> RUN, or -> DONE if loaded time is 00:00; pause ignored; start+pause together: start wins.
REQ-018 RUN: each oneHz tick decrements time by one second; pause -> PAUSE; start ignored.
REQ-019 RUN: a decrement producing 00:00 SHALL enter DONE on the same edge the time register becomes 00:00.
REQ-020 RUN: tick coincident with pause SHALL decrement first, then enter PAUSE (PAUSE then holds the decremented time).
REQ-021 PAUSE: time frozen, ticks ignored; pause -> RUN; start -> reload START value, -> IDLE; start+pause together: start wins.
REQ-022 DONE: time holds 00:00; start -> reload START value, -> RUN (or stays DONE if START value is 00:00); pause ignored.
REQ-023 Decrement borrow: so>0: so-1; else so=9 and st>0: st-1; else st=5 and borrow into minutes (mo>0: mo-1; else mo=9, mt-1); time never decrements below 00:00.
REQ-024 SHALL keep a 2-bit scan index advancing by 1 on each segClock tick, wrapping 3->0, in all states.
REQ-025 an SHALL be all ones except bit [index], which is 0.
REQ-026 seg SHALL be the standard active-low hex-free decode of the selected digit (0=7'b1000000, 1=7'b1111001, ... 9=7'b0010000).
REQ-027 Leading-zero blank: when index=3 and mt=0, seg SHALL be 7'b1111111.
REQ-028 dp SHALL be 0 only when index=2, except in PAUSE where it is 0 at index=2 only while oneHzClock is high (blinking colon); otherwise 1.
REQ-029 DONE: all digits blink — seg forced to 7'b1111111 while oneHzClock is low.
REQ-030 seg, an, dp, running, time_up SHALL be registered; each reflects state/index/time with exactly one clk cycle of latency.

Reset
REQ-031 On rst high at a clk edge: state=IDLE, time=START value, scan index=0, edge-detect history=0, regardless of state or pending start/pause.
REQ-032 Cycle after reset: an=4'b1110, seg=decode(START_SEC ones digit), dp=1, running=0, time_up=0.
REQ-033 rst has priority over start, pause, and ticks arriving on the same edge.

Verification
REQ-034 START_MIN=1, START_SEC=5; rst, start pulse, 6 oneHz ticks -> time 00:59, running=1; after 59 more ticks -> 00:00, time_up=1, running=0 on that edge+1.
REQ-035 START_MIN=10, START_SEC=0, RUN, one tick -> 09:59; display scan shows digit3 blank? no: mt=0 -> blank, digits 9,5,9.
REQ-036 In RUN at 00:30, pause and tick same cycle -> PAUSE at 00:29; 5 ticks -> still 00:29; pause -> RUN; next tick -> 00:28.
REQ-037 Drive 8 segClock ticks -> an sequence 1110,1101,1011,0111,1110,... each change one clk after tick; dp=0 only with an=1011.
REQ-038 Assert rst mid-RUN at 00:17 with start high same cycle -> IDLE, time=START value, an=4'b1110, running=0.
REQ-039 START_MIN=0, START_SEC=0, start -> DONE directly, time_up=1; start again -> stays DONE.
